// File: rtl/cineraria_led_pkg.sv
// Shared constants for the LED dimmer: register map, CTRL fields, reset defaults.
package cineraria_led_pkg;

    localparam int LED_W_DEF = 10;

    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_PRESCALE = 2'd1;
    localparam logic [1:0] ADDR_BLINK    = 2'd2;
    localparam logic [1:0] ADDR_STATUS   = 2'd3;

    localparam int CTRL_ENABLE_BIT   = 0;
    localparam int CTRL_BLINK_EN_BIT = 1;
    localparam int CTRL_BRIGHT_LSB   = 8;
    localparam int CTRL_BRIGHT_MSB   = 15;

    localparam logic [15:0] PRESCALE_RST_DEF = 16'h00C3;
    localparam logic [15:0] BLINK_RST_DEF    = 16'h01F4;
    localparam logic [7:0]  BRIGHT_RST_DEF   = 8'h80;

    localparam logic [7:0]  PWM_LAST = 8'hFF;

    // Assemble the CTRL read word from its fields; unused bits read as zero.
    function automatic logic [31:0] pack_ctrl(input logic [7:0] bright,
                                              input logic       blink_en,
                                              input logic       enable);
        return {16'h0000, bright, 6'b000000, blink_en, enable};
    endfunction

endpackage

// File: rtl/cineraria_led_pwm_timebase.sv
// PWM timebase: prescaler producing a step tick, 8-bit PWM step counter,
// and the end-of-frame pulse on the last step of each 256-step frame.
module cineraria_led_pwm_timebase
    import cineraria_led_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] i_prescale,
    input  logic        i_pre_clr,
    output logic        o_tick,
    output logic        o_frame_end,
    output logic [7:0]  o_pwm_cnt
);

    logic [15:0] r_pre_cnt;
    logic [7:0]  r_pwm_cnt;

    // Tick is judged against the register value in force this cycle, so a
    // PRESCALE write landing on a tick edge still delivers that tick.
    assign o_tick      = (r_pre_cnt == i_prescale);
    assign o_frame_end = o_tick && (r_pwm_cnt == PWM_LAST);
    assign o_pwm_cnt   = r_pwm_cnt;

    // Prescaler and PWM step counter; the step counter wraps naturally at 8 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre_cnt <= 16'd0;
            r_pwm_cnt <= 8'd0;
        end else begin
            if (i_pre_clr || o_tick) begin
                r_pre_cnt <= 16'd0;
            end else begin
                r_pre_cnt <= r_pre_cnt + 16'd1;
            end
            if (o_tick) begin
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/cineraria_led_dimmer.sv
// LED dimmer stage after the LED PIO: global PWM brightness, optional blink
// gating and bypass, with an Avalon-MM register file (combinational read).
module cineraria_led_dimmer
    import cineraria_led_pkg::*;
#(
    parameter int          LED_W        = LED_W_DEF,
    parameter logic [15:0] PRESCALE_RST = PRESCALE_RST_DEF,
    parameter logic [15:0] BLINK_RST    = BLINK_RST_DEF,
    parameter logic [7:0]  BRIGHT_RST   = BRIGHT_RST_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [LED_W-1:0] led_in,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [LED_W-1:0] led_out
);

    logic        r_enable;
    logic        r_blink_en;
    logic [7:0]  r_bright;
    logic [15:0] r_prescale;
    logic [15:0] r_blink;
    logic [15:0] r_blk_cnt;
    logic        r_phase;
    logic [LED_W-1:0] r_led_out;

    logic        w_wr;
    logic        w_pre_clr;
    logic        w_tick;
    logic        w_frame_end;
    logic [7:0]  w_pwm_cnt;
    logic        w_blink_active;
    logic        w_phase;
    logic        w_pwm_on;

    assign w_wr      = chipselect && !write_n;
    assign w_pre_clr = w_wr && (address == ADDR_PRESCALE);

    cineraria_led_pwm_timebase u_timebase (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_prescale  (r_prescale),
        .i_pre_clr   (w_pre_clr),
        .o_tick      (w_tick),
        .o_frame_end (w_frame_end),
        .o_pwm_cnt   (w_pwm_cnt)
    );

    // Blink only runs with blink_en set and a non-zero half-period; otherwise
    // the visible phase is held high without waiting for the register to settle.
    assign w_blink_active = r_blink_en && (r_blink != 16'd0);
    assign w_phase        = r_phase || !w_blink_active;
    assign w_pwm_on       = (w_pwm_cnt < r_bright);

    // Register file writes; STATUS is read-only so address 3 has no write path.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_enable   <= 1'b0;
            r_blink_en <= 1'b0;
            r_bright   <= BRIGHT_RST;
            r_prescale <= PRESCALE_RST;
            r_blink    <= BLINK_RST;
        end else if (w_wr) begin
            case (address)
                ADDR_CTRL: begin
                    r_enable   <= writedata[CTRL_ENABLE_BIT];
                    r_blink_en <= writedata[CTRL_BLINK_EN_BIT];
                    r_bright   <= writedata[CTRL_BRIGHT_MSB:CTRL_BRIGHT_LSB];
                end
                ADDR_PRESCALE: r_prescale <= writedata[15:0];
                ADDR_BLINK:    r_blink    <= writedata[15:0];
                default: ;
            endcase
        end
    end

    // Blink half-period counter; >= catches a BLINK shrunk below the current count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blk_cnt <= 16'd0;
            r_phase   <= 1'b1;
        end else if (!w_blink_active) begin
            r_blk_cnt <= 16'd0;
            r_phase   <= 1'b1;
        end else if (w_frame_end) begin
            if (r_blk_cnt >= (r_blink - 16'd1)) begin
                r_blk_cnt <= 16'd0;
                r_phase   <= !r_phase;
            end else begin
                r_blk_cnt <= r_blk_cnt + 16'd1;
            end
        end
    end

    // Registered LED drive: bypass when disabled, else gated by PWM and blink phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_led_out <= '0;
        end else if (!r_enable) begin
            r_led_out <= led_in;
        end else begin
            r_led_out <= led_in & {LED_W{w_pwm_on && w_phase}};
        end
    end

    assign led_out = r_led_out;

    // Combinational read mux; chipselect is not needed to read.
    always_comb begin
        readdata = 32'h0000_0000;
        case (address)
            ADDR_CTRL:     readdata = pack_ctrl(r_bright, r_blink_en, r_enable);
            ADDR_PRESCALE: readdata = {16'h0000, r_prescale};
            ADDR_BLINK:    readdata = {16'h0000, r_blink};
            ADDR_STATUS:   readdata = {16'h0000, w_pwm_cnt, 7'b0000000, w_phase};
            default:       readdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: tb/tb_cineraria_led_dimmer.sv
// Self-checking bench for the LED dimmer: bypass, PWM duty, blink, prescaler
// restart, register map and asynchronous reset.
module tb_cineraria_led_dimmer;
    import cineraria_led_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [9:0]  led_in;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  led_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_v;

    cineraria_led_dimmer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .led_in     (led_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .led_out    (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic reset_dut();
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        address    = 2'd0;
        led_in     = 10'h000;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Single-cycle write; returns #1 after the write edge.
    task automatic avm_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic test_reset();
        reset_dut();
        sb_q.push_back(32'h0);
        exp_v = sb_q.pop_front();
        n_tests++;
        if ({22'h0, led_out} !== exp_v) begin
            $display("FAIL reset_led_out: got %h want %h", led_out, exp_v[9:0]);
            n_fail++;
        end
        for (int a = 0; a < 4; a++) begin
            case (a)
                0: sb_q.push_back(32'h0000_8000);
                1: sb_q.push_back(32'h0000_00C3);
                2: sb_q.push_back(32'h0000_01F4);
                default: sb_q.push_back(32'h0000_0001);
            endcase
            address = a[1:0];
            #1;
            exp_v = sb_q.pop_front();
            n_tests++;
            if (readdata !== exp_v) begin
                $display("FAIL reset_reg%0d: got %h want %h", a, readdata, exp_v);
                n_fail++;
            end
        end
    endtask

    task automatic test_bypass();
        reset_dut();
        avm_write(ADDR_CTRL, 32'h0);
        led_in = 10'h2A5;
        sb_q.push_back(32'h2A5);
        @(posedge clk); #1;
        exp_v = sb_q.pop_front();
        n_tests++;
        if ({22'h0, led_out} !== exp_v) begin
            $display("FAIL bypass_2a5: got %h want %h", led_out, exp_v[9:0]);
            n_fail++;
        end
        address = ADDR_STATUS;
        #1;
        n_tests++;
        if (readdata[0] !== 1'b1) begin
            $display("FAIL bypass_phase: got %b want 1", readdata[0]);
            n_fail++;
        end
        for (int i = 0; i < 20; i++) begin
            led_in = 10'($urandom_range(0, 1023));
            sb_q.push_back({22'h0, led_in});
            @(posedge clk); #1;
            exp_v = sb_q.pop_front();
            n_tests++;
            if ({22'h0, led_out} !== exp_v) begin
                $display("FAIL bypass_b2b[%0d]: got %h want %h", i, led_out, exp_v[9:0]);
                n_fail++;
            end
        end
    endtask

    // PRESCALE=0 gives one step per cycle; after the PRESCALE write edge E the
    // step count after edge E+k is k mod 256, and led_out after E+j reflects step j-1.
    task automatic test_pwm(input logic [7:0] br, input int ncyc);
        int high;
        int exp_high;
        high = 0;
        reset_dut();
        led_in = 10'h3FF;
        avm_write(ADDR_PRESCALE, 32'h0);
        avm_write(ADDR_CTRL, {16'h0, br, 8'h01});
        for (int j = 2; j < 2 + ncyc; j++) begin
            sb_q.push_back((((j - 1) % 256) < int'(br)) ? 32'h3FF : 32'h0);
            @(posedge clk); #1;
            exp_v = sb_q.pop_front();
            n_tests++;
            if ({22'h0, led_out} !== exp_v) begin
                $display("FAIL pwm_br%0d_j%0d: got %h want %h", br, j, led_out, exp_v[9:0]);
                n_fail++;
            end
            if (led_out == 10'h3FF) high++;
        end
        exp_high = (ncyc / 256) * int'(br);
        n_tests++;
        if (high !== exp_high) begin
            $display("FAIL pwm_br%0d_count: got %0d want %0d", br, high, exp_high);
            n_fail++;
        end
    endtask

    task automatic test_blink();
        bit ph_prev;
        bit ph_now;
        reset_dut();
        led_in = 10'h3FF;
        avm_write(ADDR_PRESCALE, 32'h0);
        avm_write(ADDR_BLINK, 32'h2);
        avm_write(ADDR_CTRL, 32'h0000_FF03);
        address = ADDR_STATUS;
        for (int j = 3; j < 2100; j++) begin
            ph_prev = (((j - 1) / 512) % 2) == 0;
            ph_now  = ((j / 512) % 2) == 0;
            sb_q.push_back(((((j - 1) % 256) < 255) && ph_prev) ? 32'h3FF : 32'h0);
            @(posedge clk); #1;
            exp_v = sb_q.pop_front();
            n_tests++;
            if ({22'h0, led_out} !== exp_v) begin
                $display("FAIL blink_led_j%0d: got %h want %h", j, led_out, exp_v[9:0]);
                n_fail++;
            end
            n_tests++;
            if (readdata[0] !== ph_now || readdata[15:8] !== 8'(j % 256)) begin
                $display("FAIL blink_status_j%0d: got phase=%b pwm=%0d want phase=%b pwm=%0d",
                         j, readdata[0], readdata[15:8], ph_now, j % 256);
                n_fail++;
            end
        end
    endtask

    task automatic test_prescale();
        reset_dut();
        repeat (50) @(posedge clk);
        #1;
        avm_write(ADDR_PRESCALE, 32'h3);
        address = ADDR_STATUS;
        for (int k = 1; k < 40; k++) begin
            sb_q.push_back(32'(k / 4));
            @(posedge clk); #1;
            exp_v = sb_q.pop_front();
            n_tests++;
            if ({24'h0, readdata[15:8]} !== exp_v) begin
                $display("FAIL prescale3_k%0d: got pwm=%0d want %0d", k, readdata[15:8], exp_v);
                n_fail++;
            end
        end
        // This write edge coincides with a tick; the tick must still count.
        avm_write(ADDR_PRESCALE, 32'h1);
        address = ADDR_STATUS;
        #1;
        n_tests++;
        if (readdata[15:8] !== 8'd10) begin
            $display("FAIL prescale_tick_write: got pwm=%0d want 10", readdata[15:8]);
            n_fail++;
        end
        for (int k = 1; k <= 20; k++) begin
            sb_q.push_back(32'(10 + k / 2));
            @(posedge clk); #1;
            exp_v = sb_q.pop_front();
            n_tests++;
            if ({24'h0, readdata[15:8]} !== exp_v) begin
                $display("FAIL prescale1_k%0d: got pwm=%0d want %0d", k, readdata[15:8], exp_v);
                n_fail++;
            end
        end
    endtask

    task automatic test_regs();
        reset_dut();
        avm_write(ADDR_CTRL,     32'hFFFF_FFFF);
        avm_write(ADDR_PRESCALE, 32'hABCD_1234);
        avm_write(ADDR_BLINK,    32'h5555_0007);
        avm_write(ADDR_STATUS,   32'hFFFF_FFFF);
        for (int a = 0; a < 4; a++) begin
            case (a)
                0: sb_q.push_back(32'h0000_FF03);
                1: sb_q.push_back(32'h0000_1234);
                2: sb_q.push_back(32'h0000_0007);
                default: sb_q.push_back(32'h0000_0001);
            endcase
            address = a[1:0];
            #1;
            exp_v = sb_q.pop_front();
            n_tests++;
            if (readdata !== exp_v) begin
                $display("FAIL regs_rb%0d: got %h want %h", a, readdata, exp_v);
                n_fail++;
            end
        end
    endtask

    task automatic test_reset_midframe();
        reset_dut();
        led_in = 10'h3FF;
        avm_write(ADDR_PRESCALE, 32'h0);
        avm_write(ADDR_CTRL, 32'h0000_2001);
        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if (led_out !== 10'h3FF) begin
            $display("FAIL midframe_pre: got %h want 3ff", led_out);
            n_fail++;
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if (led_out !== 10'h000) begin
            $display("FAIL midframe_async: got %h want 000", led_out);
            n_fail++;
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            case (a)
                0: sb_q.push_back(32'h0000_8000);
                1: sb_q.push_back(32'h0000_00C3);
                2: sb_q.push_back(32'h0000_01F4);
                default: sb_q.push_back(32'h0000_0001);
            endcase
            address = a[1:0];
            #1;
            exp_v = sb_q.pop_front();
            n_tests++;
            if (readdata !== exp_v) begin
                $display("FAIL midframe_reg%0d: got %h want %h", a, readdata, exp_v);
                n_fail++;
            end
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        address    = 2'd0;
        led_in     = 10'h000;
        test_reset();
        test_bypass();
        test_pwm(8'h40, 512);
        test_pwm(8'h00, 1024);
        test_pwm(8'hFF, 512);
        test_blink();
        test_prescale();
        test_regs();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cineraria_led_dimmer.md
Name: cineraria_led_dimmer

Overview:
Downstream stage of the 10-bit LED PIO. Takes the PIO's registered output vector and applies three effects before driving the board LED pins: global PWM brightness, optional blink gating, and a bypass mode. Control registers sit on an Avalon-MM slave in the same system, with the same single-cycle write and combinational read style as the PIO.

Parameters:
- LED_W, 10: width of the LED vector.
- PRESCALE_RST, 16'h00C3: reset value of PRESCALE. One PWM step = 196 clk cycles, giving a frame of about 1 kHz at 50 MHz.
- BLINK_RST, 16'h01F4: reset value of BLINK, 500 frames per half-period.
- BRIGHT_RST, 8'h80: reset brightness.

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: reset, asynchronous, active-low.
- led_in, in, LED_W: LED pattern from the PIO out_port.
- address, in, 2: Avalon-MM register index.
- chipselect, in, 1: slave select.
- write_n, in, 1: active-low write strobe.
- writedata, in, 32: write data.
- readdata, out, 32: read data, combinational.
- led_out, out, LED_W: registered drive to the LED pins.

Behaviour:
- Reset is asynchronous, active-low, on clk. In reset:
  - CTRL = {BRIGHT_RST, 6'b0, blink_en=0, enable=0}, PRESCALE = PRESCALE_RST, BLINK = BLINK_RST.
  - pre_cnt = 0, pwm_cnt = 0, blk_cnt = 0, phase = 1, led_out = 0.
- Register map. A write takes effect when chipselect && !write_n. Unused bits read 0.
  - 0 CTRL (R/W): [0] enable, [1] blink_en, [15:8] bright.
  - 1 PRESCALE (R/W): [15:0].
  - 2 BLINK (R/W): [15:0].
  - 3 STATUS (RO): [0] phase, [15:8] pwm_cnt. Writes to address 3 are ignored.
- Prescaler:
  - pre_cnt counts 0..PRESCALE. tick = (pre_cnt == PRESCALE); on tick pre_cnt returns to 0.
  - PRESCALE = 0 gives a tick every cycle.
  - Any write to PRESCALE clears pre_cnt in the same edge. The new value governs from the next cycle.
- PWM counter:
  - 8-bit pwm_cnt increments on tick and wraps 255 -> 0.
  - frame_end = tick && pwm_cnt == 255.
  - pwm_on = (pwm_cnt < bright). bright = 0 means always off; bright = 255 means on 255 of 256 steps.
- Blink:
  - On frame_end, if blink_en: when blk_cnt == BLINK - 1, phase toggles and blk_cnt clears; otherwise blk_cnt increments.
  - BLINK = 0: phase forced to 1 and blk_cnt held at 0.
  - blink_en = 0: phase forced to 1 and blk_cnt cleared.
  - If a BLINK write leaves blk_cnt >= BLINK - 1, the next frame_end toggles phase and clears blk_cnt.
- Output, registered with 1-cycle latency from the led_in and counter state of the previous cycle:
  - enable = 0: led_out <= led_in (bypass; counters keep running).
  - enable = 1: led_out <= led_in & {LED_W{pwm_on && phase}}.
- Simultaneous events: a register write on a tick cycle uses the new value from the next cycle. The tick/frame_end in that cycle still evaluates against the old values.
- Reset mid-frame returns all state to the reset values immediately, and led_out goes to 0 asynchronously.
- readdata is combinational from address. chipselect is not required for reads, matching the PIO convention.

Decomposition:
- Shared package cineraria_led_pkg holds:
  - register address constants ADDR_CTRL=0, ADDR_PRESCALE=1, ADDR_BLINK=2, ADDR_STATUS=3;
  - CTRL bit-field constants;
  - the reset-default constants.
- One natural sub-module, cineraria_led_pwm_timebase: prescaler, pwm_cnt and frame_end generation.
- The register file, blink logic and output gating stay in the top.

Test Plan:
- Reset, then write CTRL=0, drive led_in=10'h2A5 -> led_out=10'h2A5 one cycle later. Read STATUS phase=1.
- PRESCALE=0, CTRL={bright=8'h40, enable=1}, led_in=10'h3FF -> over 256 cycles led_out=10'h3FF for exactly 64 cycles, then 10'h000 for 192 cycles, repeating.
- bright=0, enable=1 -> led_out stays 0 for 1024 cycles. bright=255 -> led_out high 255 of every 256 cycles.
- PRESCALE=0, BLINK=2, blink_en=1, bright=255 -> phase toggles every 512 cycles; STATUS[0] matches; led_out fully dark during phase=0.
- Write PRESCALE=3 in the middle of a count -> pre_cnt restarts and ticks arrive every 4 cycles thereafter. A write on a tick cycle does not lose that tick.
- Assert reset_n low mid-frame with led_out nonzero -> led_out=0 immediately. After release, registers read back PRESCALE=16'h00C3, BLINK=16'h01F4, CTRL=32'h00008000.
